// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared widths, opcode constants, field bounds and state encoding for the fetch unit
package ifu_pkg;

    localparam int INS_W      = 24;
    localparam int PC_W       = 8;
    localparam int IMEM_DEPTH = 256;

    localparam int OPC_HI     = 23;
    localparam int OPC_LO     = 19;
    localparam int OPC_W      = OPC_HI - OPC_LO + 1;
    localparam int TGT_HI     = 18;
    localparam int TGT_LO     = 11;

    localparam logic [OPC_W-1:0] OPC_JMP    = 5'b11000;
    localparam logic [2:0]       OPC_COND_J = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_HALTED = 2'b11
    } ifu_state_e;

endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - 256x24 instruction store, synchronous write, asynchronous read
module instr_mem
    import ifu_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [PC_W-1:0]  waddr,
    input  logic [INS_W-1:0] wdata,
    input  logic [PC_W-1:0]  raddr,
    output logic [INS_W-1:0] rdata
);

    logic [INS_W-1:0] mem [0:IMEM_DEPTH-1];

    // Program load; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC sequencing, jump redirect with one-cycle bubble, stall/halt control
module instruction_fetch_unit
    import ifu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             cond_taken,
    input  logic             prog_we,
    input  logic [PC_W-1:0]  prog_addr,
    input  logic [INS_W-1:0] prog_data,
    output logic [INS_W-1:0] ins,
    output logic [PC_W-1:0]  pc_out,
    output logic             fetch_valid,
    output logic [1:0]       state_out
);

    ifu_state_e       state;
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] fetch_word;
    logic [OPC_W-1:0] opcode;
    logic [PC_W-1:0]  target;
    logic             is_jmp;
    logic             is_cond_j;
    logic             redirect;

    // Memory may only be loaded while the unit is parked in IDLE
    instr_mem u_imem (
        .clk   (clk),
        .we    (prog_we && (state == ST_IDLE)),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (fetch_word)
    );

    assign opcode    = ins[OPC_HI:OPC_LO];
    assign target    = ins[TGT_HI:TGT_LO];
    assign is_jmp    = (opcode == OPC_JMP);
    assign is_cond_j = (opcode[OPC_W-1 -: 3] == OPC_COND_J);
    // ins is forced to zero during FLUSH, so only RUN can see a jump to act on
    assign redirect  = (state == ST_RUN) && (is_jmp || (is_cond_j && cond_taken));

    assign state_out = state;

    // Fetch FSM: stall freezes everything; halt wins the next state but a coincident jump still retargets pc
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= '0;
            ins         <= '0;
            pc_out      <= '0;
            fetch_valid <= 1'b0;
        end else if (!stall) begin
            case (state)
                ST_IDLE: begin
                    pc          <= '0;
                    ins         <= '0;
                    fetch_valid <= 1'b0;
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN, ST_FLUSH: begin
                    if (halt) begin
                        state       <= ST_HALTED;
                        ins         <= '0;
                        fetch_valid <= 1'b0;
                        if (redirect) begin
                            pc <= target;
                        end
                    end else if (redirect) begin
                        state       <= ST_FLUSH;
                        pc          <= target;
                        ins         <= '0;
                        fetch_valid <= 1'b0;
                    end else begin
                        state       <= ST_RUN;
                        ins         <= fetch_word;
                        pc_out      <= pc;
                        fetch_valid <= 1'b1;
                        pc          <= pc + PC_W'(1);
                    end
                end
                ST_HALTED: begin
                    ins         <= '0;
                    fetch_valid <= 1'b0;
                    if (start && !halt) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
